// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide unit for a MIPS-style E stage.
// Division is restoring radix-2, one quotient bit per cycle over 32 cycles,
// then a DONE state that waits for the rest of the pipeline to release E.
// Optional macro MULDIV_MULT_2CYC_EN: registers multiply operands and writes
// the product one cycle later through a MUL state. Without it, multiply
// writes HI/LO at the end of the issue cycle with no stall.
module muldiv_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mult_e,
   input  logic              multu_e,
   input  logic              div_e,
   input  logic              divu_e,
   input  logic              mthi_e,
   input  logic              mtlo_e,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush_e,
   input  logic              stall_ext,
   output logic              stall_e,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   localparam logic [1:0] IDLE = 2'd0;
`ifdef MULDIV_MULT_2CYC_EN
   localparam logic [1:0] MUL  = 2'd1;
`endif
   localparam logic [1:0] DIV  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;   // partial remainder
   logic [DATA_W-1:0] quo_q, quo_d;   // dividend shifting out, quotient shifting in
   logic [DATA_W-1:0] dvs_q, dvs_d;   // divisor magnitude (multiplier B in MUL)
   logic              qneg_q, qneg_d; // quotient sign (multiply signedness in MUL)
   logic              rneg_q, rneg_d; // remainder sign
   logic              dz_q, dz_d;     // divisor was zero

   logic              op_div, op_mul;
   logic [DATA_W:0]   shifted;
   logic              ge;
   logic [DATA_W-1:0] rem_step, quo_step;

   function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? -v : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] mul_wide(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic              sgn);
      logic signed [2*DATA_W-1:0] ax, bx;
      ax = $signed({{DATA_W{sgn & a[DATA_W-1]}}, a});
      bx = $signed({{DATA_W{sgn & b[DATA_W-1]}}, b});
      return ax * bx;
   endfunction

   assign op_div = div_e | divu_e;
   assign op_mul = mult_e | multu_e;

   // Next-state, divide step and HI/LO update logic
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;

      shifted  = {rem_q, quo_q[DATA_W-1]};
      ge       = (shifted >= {1'b0, dvs_q});
      rem_step = ge ? DATA_W'(shifted - {1'b0, dvs_q}) : shifted[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], ge};

      case (state_q)
         IDLE: begin
            if (!flush_e) begin
               if (op_div) begin
                  quo_d   = div_e ? abs_val(src_a) : src_a;
                  dvs_d   = div_e ? abs_val(src_b) : src_b;
                  qneg_d  = div_e & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                  rneg_d  = div_e & src_a[DATA_W-1];
                  dz_d    = (src_b == '0);
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = DIV;
               end else if (op_mul) begin
`ifdef MULDIV_MULT_2CYC_EN
                  quo_d   = src_a;
                  dvs_d   = src_b;
                  qneg_d  = mult_e;
                  state_d = MUL;
`else
                  {hi_d, lo_d} = mul_wide(src_a, src_b, mult_e);
`endif
               end else if (mthi_e) begin
                  hi_d = src_a;
               end else if (mtlo_e) begin
                  lo_d = src_a;
               end
            end
         end
`ifdef MULDIV_MULT_2CYC_EN
         MUL: begin
            if (flush_e) begin
               state_d = IDLE;
            end else begin
               {hi_d, lo_d} = mul_wide(quo_q, dvs_q, qneg_q);
               state_d      = DONE;
            end
         end
`endif
         DIV: begin
            if (flush_e) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_step;
               quo_d = quo_step;
               if (cnt_q == LAST) begin
                  state_d = DONE;
                  // With a zero divisor the remainder ends up holding the
                  // dividend magnitude, so re-applying its sign recovers the
                  // dividend exactly as it was latched.
                  hi_d = rneg_q ? -rem_step : rem_step;
                  lo_d = dz_q ? '1 : (qneg_q ? -quo_step : quo_step);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (flush_e || !stall_ext) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   // Stall request: issue cycle of a multicycle op plus every busy compute cycle
   always_comb begin
`ifdef MULDIV_MULT_2CYC_EN
      stall_e = resetn && !flush_e &&
                (((state_q == IDLE) && (op_div || op_mul)) ||
                 (state_q == DIV) || (state_q == MUL));
`else
      stall_e = resetn && !flush_e &&
                (((state_q == IDLE) && op_div) || (state_q == DIV));
`endif
   end

   assign busy = (state_q != IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mult_e, multu_e, div_e, divu_e, mthi_e, mtlo_e;
   logic [31:0] src_a, src_b;
   logic        flush_e, stall_ext;
   logic        stall_e, busy;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   muldiv_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .mult_e    (mult_e),
      .multu_e   (multu_e),
      .div_e     (div_e),
      .divu_e    (divu_e),
      .mthi_e    (mthi_e),
      .mtlo_e    (mtlo_e),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush_e   (flush_e),
      .stall_ext (stall_ext),
      .stall_e   (stall_e),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mult_e = 0; multu_e = 0; div_e = 0; divu_e = 0; mthi_e = 0; mtlo_e = 0;
      flush_e = 0;
   endtask

   // Full divide: issue at T, 32 compute cycles, DONE held by stall_ext for
   // 'hold' cycles, then the op leaves E.
   task automatic div_op(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      src_a = a; src_b = b;
      if (sgn) div_e = 1; else divu_e = 1;
      #1 chk({tag, " stall T"}, {31'b0, stall_e}, 32'd1);
      for (int i = 1; i <= 32; i++) begin
         cyc();
         chk({tag, " stall run"}, {31'b0, stall_e}, 32'd1);
      end
      cyc();
      stall_ext = (hold > 0);
      #1;
      chk({tag, " stall T+33"}, {31'b0, stall_e}, 32'd0);
      chk({tag, " lo"}, lo, exp_lo);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " busy done"}, {31'b0, busy}, 32'd1);
      for (int k = 1; k < hold; k++) begin
         cyc();
         chk({tag, " held busy"}, {31'b0, busy}, 32'd1);
         chk({tag, " held stall"}, {31'b0, stall_e}, 32'd0);
      end
      if (hold > 0) begin
         cyc();
         stall_ext = 0;
         #1 chk({tag, " release busy"}, {31'b0, busy}, 32'd1);
      end
      cyc();
      idle_inputs();
      #1;
      chk({tag, " idle busy"}, {31'b0, busy}, 32'd0);
      chk({tag, " idle stall"}, {31'b0, stall_e}, 32'd0);
      chk({tag, " keep lo"}, lo, exp_lo);
      chk({tag, " keep hi"}, hi, exp_hi);
   endtask

   // Multiply with the expected timing of the selected build.
   task automatic mul_op(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      src_a = a; src_b = b;
      if (sgn) mult_e = 1; else multu_e = 1;
`ifdef MULDIV_MULT_2CYC_EN
      #1 chk({tag, " stall T"}, {31'b0, stall_e}, 32'd1);
      cyc();
      chk({tag, " stall T+1"}, {31'b0, stall_e}, 32'd1);
      chk({tag, " busy T+1"}, {31'b0, busy}, 32'd1);
      cyc();
      chk({tag, " stall done"}, {31'b0, stall_e}, 32'd0);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
      cyc();
      idle_inputs();
      #1 chk({tag, " idle busy"}, {31'b0, busy}, 32'd0);
`else
      #1 chk({tag, " stall T"}, {31'b0, stall_e}, 32'd0);
      cyc();
      idle_inputs();
      #1;
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
      chk({tag, " busy"}, {31'b0, busy}, 32'd0);
`endif
   endtask

   initial begin
      idle_inputs();
      stall_ext = 0;
      src_a = 0; src_b = 0;
      resetn = 0;
      div_e = 1;
      cyc(); cyc();
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset stall", {31'b0, stall_e}, 32'd0);
      div_e = 0;
      resetn = 1;

      // MTHI / MTLO
      cyc();
      src_a = 32'hA5A5_0001; mthi_e = 1;
      #1 chk("mthi stall", {31'b0, stall_e}, 32'd0);
      cyc();
      mthi_e = 0; src_a = 32'h5A5A_0002; mtlo_e = 1;
      #1 chk("mthi hi", hi, 32'hA5A5_0001);
      cyc();
      mtlo_e = 0;
      #1;
      chk("mtlo lo", lo, 32'h5A5A_0002);
      chk("mtlo hi kept", hi, 32'hA5A5_0001);

      // Divides
      cyc();
      div_op("divu 100/7", 1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2);
      div_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

      // Multiplies
      mul_op("mult", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      mul_op("multu", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);

      // Divide by zero with DONE held by stall_ext
      div_op("divu 5/0", 1'b0, 32'd5, 32'd0, 3, 32'hFFFF_FFFF, 32'd5);

      // Flush at T+10 of DIV 9/3
      src_a = 32'd9; src_b = 32'd3; div_e = 1;
      #1 chk("flush10 stall T", {31'b0, stall_e}, 32'd1);
      for (int i = 1; i <= 9; i++) cyc();
      cyc();
      flush_e = 1;
      #1;
      chk("flush10 stall", {31'b0, stall_e}, 32'd0);
      chk("flush10 busy", {31'b0, busy}, 32'd1);
      cyc();
      idle_inputs();
      #1;
      chk("flush10 idle", {31'b0, busy}, 32'd0);
      chk("flush10 hi", hi, 32'd5);
      chk("flush10 lo", lo, 32'hFFFF_FFFF);

      // Flush in the issue cycle suppresses start and MTHI
      cyc();
      src_a = 32'h0000_DEAD; div_e = 1; flush_e = 1;
      #1 chk("flushT stall", {31'b0, stall_e}, 32'd0);
      cyc();
      div_e = 0; mthi_e = 1;
      #1 chk("flushT busy", {31'b0, busy}, 32'd0);
      cyc();
      idle_inputs();
      #1 chk("flush mthi hi", hi, 32'd5);

      // Signed boundaries
      cyc();
      div_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0);
      div_op("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

      // Reset mid-divide at T+5
      src_a = 32'd100; src_b = 32'd7; div_e = 1;
      for (int i = 1; i <= 5; i++) cyc();
      resetn = 0;
      #1;
      chk("rst mid hi", hi, 32'd0);
      chk("rst mid lo", lo, 32'd0);
      chk("rst mid busy", {31'b0, busy}, 32'd0);
      chk("rst mid stall", {31'b0, stall_e}, 32'd0);
      cyc();
      idle_inputs();
      resetn = 1;
      cyc();
      div_op("div after rst", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
